kmer_builder: RTL
=================

KMER_BUILDER -- requirements
Module: kmer_builder

Interface
REQ-001 SHALL have parameter K, default 31, k-mer length in bases (legal range 1..31).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_base  input  8  one ASCII nucleotide character.
REQ-005 SHALL have port in_valid  input  1  in_base/in_last valid this cycle; no backpressure.
REQ-006 SHALL have port in_last  input  1  qualifies in_base as the final character of the current read.
REQ-007 SHALL have port out_data  output  62  k-mer, 2 bits/base, newest base in bits [1:0], unused upper bits zero when K<31.
REQ-008 SHALL have port out_valid  output  1  out_data valid, single-cycle pulse per k-mer.
REQ-009 SHALL have port kmer_count  output  32  total k-mers emitted since reset.
REQ-010 SHALL have port bad_base_count  output  32  total non-ACGT characters accepted since reset.

Function
REQ-011 SHALL encode A/a=2'b00, C/c=2'b01, G/g=2'b10, T/t=2'b11 (complement = bitwise NOT, matching the downstream canonicalisation stage).
REQ-012 SHALL treat every other byte value (N, n, 0x00, etc.) as an invalid base.
REQ-013 SHALL hold a window register W[2K-1:0] and a fill counter F (6 bits, 0..K).
REQ-014 On a valid ACGT character: W <= {W[2K-3:0], code}; F <= min(F+1, K) (saturating).
REQ-015 On a valid invalid character: F <= 0, bad_base_count +1, W contents don't-care, no k-mer emitted.
REQ-016 SHALL assert out_valid on the cycle after a valid ACGT character that makes F (post-update) equal K, with out_data = updated W zero-extended to 62 bits.
REQ-017 Latency in_valid -> out_valid SHALL be exactly 1 cycle; outputs registered.
REQ-018 out_valid SHALL be 0 in all other cycles; out_data SHALL hold its last value when out_valid is 0.
REQ-019 kmer_count SHALL increment in the same cycle out_valid is asserted, wrapping 0xFFFFFFFF -> 0.
REQ-020 bad_base_count SHALL wrap 0xFFFFFFFF -> 0.
REQ-021 in_last with a valid ACGT base: the base is processed (may emit a k-mer), then F SHALL be 0 for the next accepted character.
REQ-022 in_last with an invalid base: identical to REQ-015.
REQ-023 in_valid=0 cycles SHALL leave W, F and counters unchanged (gaps between bases are transparent).
REQ-024 in_base and in_last SHALL be ignored when in_valid=0.

Reset
REQ-025 rst=1 at a rising edge SHALL set F=0, W=0, out_valid=0, out_data=0, kmer_count=0, bad_base_count=0.
REQ-026 rst SHALL take priority over a simultaneous in_valid; that character is discarded.
REQ-027 After rst deasserts, the first K valid ACGT characters SHALL be required before any out_valid.

Verification
REQ-028 K=31: 31 x 'A' back-to-back -> single out_valid cycle after 31st, out_data=0, kmer_count=1; then 'C' -> out_valid, out_data=62'h1, kmer_count=2.
REQ-029 30 x 'A', 'N', 31 x 'T' -> no out_valid until cycle after 31st 'T'; out_data=62'h3FFF_FFFF_FFFF_FFFF; bad_base_count=1.
REQ-030 31 x 'G' with in_last on 31st, then 30 x 'g' -> exactly one out_valid (data 62'h2AAA_AAAA_AAAA_AAAA), none for the lowercase run.
REQ-031 31 x 'C' with in_valid=0 gaps of 0-3 random cycles between characters -> exactly one out_valid, 1 cycle after last 'C', out_data=62'h1555_5555_5555_5555.
REQ-032 rst asserted after 20 valid bases, 11 more bases after release -> no out_valid; 20 further bases -> first out_valid after the 31st post-reset base; counters restart from 0.

Source files
------------

// File: rtl/kmer_builder.sv
// kmer_builder: packs a stream of ASCII nucleotides into 2-bit/base k-mers and
// emits one registered k-mer per accepted base once the window holds K valid bases.
module kmer_builder #(
    parameter int K = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_base,
    input  logic        in_valid,
    input  logic        in_last,
    output logic [61:0] out_data,
    output logic        out_valid,
    output logic [31:0] kmer_count,
    output logic [31:0] bad_base_count
);
    localparam logic [5:0] KF = 6'(K);
    logic [2*K-1:0] w_q, w_d;
    logic [5:0]     f_q, f_d, f_inc;
    logic [1:0]     code;
    logic           is_acgt, accept, emit_d;
    logic           out_valid_q;
    logic [61:0]    out_data_q;
    logic [31:0]    kmer_count_q, bad_q;

    always_comb begin
        code    = 2'b00;
        is_acgt = 1'b1;
        case (in_base)
            "A", "a": code = 2'b00;
            "C", "c": code = 2'b01;
            "G", "g": code = 2'b10;
            "T", "t": code = 2'b11;
            default:  is_acgt = 1'b0;
        endcase
    end

    // Shift written as a masked OR so the K=1 window needs no special case.
    assign accept = in_valid && is_acgt;
    assign f_inc  = (f_q == KF) ? KF : f_q + 6'd1;
    assign w_d    = accept ? ((w_q << 2) | (2*K)'(code)) : w_q;
    assign f_d    = !in_valid ? f_q : (is_acgt && !in_last) ? f_inc : 6'd0;
    assign emit_d = accept && (f_inc == KF);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q          <= '0;
            f_q          <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            kmer_count_q <= '0;
            bad_q        <= '0;
        end else begin
            w_q         <= w_d;
            f_q         <= f_d;
            out_valid_q <= emit_d;
            if (emit_d) begin
                out_data_q   <= 62'(w_d);
                kmer_count_q <= kmer_count_q + 32'd1;
            end
            if (in_valid && !is_acgt)
                bad_q <= bad_q + 32'd1;
        end
    end

    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign kmer_count     = kmer_count_q;
    assign bad_base_count = bad_q;
endmodule
